// File: rtl/fwd_stream_reader_if.sv
// AXI-Stream beat channel carrying packet words out of the forwarder reader.
interface fwd_stream_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/fwd_stream_reader.sv
// Forwarder stream reader: accepts the queue head token, reads the selected
// packet buffer through a 1-cycle read port, streams it on AXI-Stream with
// tkeep/tlast, then pulses fwd_deq so the buffer returns to the free pool.
module fwd_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            fwd_token,
  output logic                  fwd_deq,
  output logic [1:0]            buf_sel,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  fwd_stream_reader_if.master   m_axis,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int NW_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state;
  logic [NW_W-1:0]   nwords;
  logic [NW_W-1:0]   rd_cnt;
  logic [LB-1:0]     last_bytes;

  // Read-return stage: one read in flight, tagged with its end-of-packet info
  logic              vld_p1;
  logic              last_p1;
  logic [BYTES-1:0]  keep_p1;

  // Two-entry skid FIFO feeding the stream output
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic [BYTES-1:0]      fifo_keep [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  fifo_vld;
  logic                  pop;
  logic [2:0]            occ;
  logic                  issue_last;

  // Number of words in a packet of len bytes, rounded up to whole words.
  function automatic logic [NW_W-1:0] word_count(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH:0] padded;
    padded = {1'b0, len} + (LEN_WIDTH + 1)'(BYTES - 1);
    return padded[LEN_WIDTH:LB];
  endfunction

  // Byte enables for the final word; a zero remainder means a full word.
  function automatic logic [BYTES-1:0] keep_mask(input logic [LB-1:0] lb);
    logic [BYTES-1:0] m;
    if (lb == '0) m = '1;
    else          m = (BYTES'(1) << lb) - BYTES'(1);
    return m;
  endfunction

  assign fifo_vld   = (fifo_cnt != 2'd0);
  assign pop        = fifo_vld & m_axis.tready;
  // Occupancy after this cycle's pop; a same-cycle pop frees a slot for a new read.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en      = (state == STREAM) && (rd_cnt < nwords) && (occ < 3'd2);
  assign rd_addr    = rd_en ? rd_cnt[ADDR_WIDTH-1:0] : '0;
  assign issue_last = (rd_cnt == nwords - NW_W'(1));
  assign busy       = (state != IDLE);

  assign m_axis.tvalid = fifo_vld;
  assign m_axis.tdata  = fifo_vld ? fifo_data[rd_ptr] : '0;
  assign m_axis.tkeep  = fifo_vld ? fifo_keep[rd_ptr] : '0;
  assign m_axis.tlast  = fifo_vld ? fifo_last[rd_ptr] : 1'b0;

  // Packet sequencing: accept token, issue reads, end on the tlast handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      buf_sel    <= 2'd0;
      nwords     <= '0;
      last_bytes <= '0;
      rd_cnt     <= '0;
      fwd_deq    <= 1'b0;
    end else begin
      fwd_deq <= 1'b0;
      case (state)
        IDLE: begin
          if (fwd_token != 2'd0) begin
            buf_sel    <= fwd_token;
            nwords     <= word_count(pkt_len);
            last_bytes <= pkt_len[LB-1:0];
            rd_cnt     <= '0;
            if (pkt_len == '0) begin
              state   <= DONE;
              fwd_deq <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_en) rd_cnt <= rd_cnt + NW_W'(1);
          if (pop && fifo_last[rd_ptr]) begin
            state   <= DONE;
            fwd_deq <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          buf_sel <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: read issued, data returns next cycle ----
  // In-flight flag for the outstanding buffer read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_en;
  end

  // End-of-packet tag travelling with the in-flight read.
  always_ff @(posedge clk) begin
    last_p1 <= issue_last;
    keep_p1 <= issue_last ? keep_mask(last_bytes) : '1;
  end

  // ---- stage p1 -> FIFO: returned word captured with its tag ----
  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  // FIFO storage; head stays put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_last[wr_ptr] <= last_p1;
      fifo_keep[wr_ptr] <= keep_p1;
    end
  end

endmodule

// File: tb/tb_fwd_stream_reader.sv
// Testbench for fwd_stream_reader: token queue and packet buffer models,
// directed timing tables plus randomized traffic against a packet scoreboard.
module tb_fwd_stream_reader;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    fwd_token;
  logic          fwd_deq;
  logic [1:0]    buf_sel;
  logic [LW-1:0] pkt_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;

  fwd_stream_reader_if #(.DATA_WIDTH(DW)) axis ();

  fwd_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .fwd_token(fwd_token), .fwd_deq(fwd_deq),
    .buf_sel(buf_sel), .pkt_len(pkt_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_axis(axis.master), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int tok; int len; } pkt_t;
  pkt_t        q[$];
  logic [63:0] bufmem [3][512];

  int n_checks = 0;
  int n_pass = 0;
  int idx = 0;
  int next_rd = 0;
  int rd_issued = 0;
  int deq_cnt = 0;
  int tready_mode = 0;
  int pat_i = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic [7:0]  prev_keep = '0;
  logic        prev_last = 1'b0;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int e_rd   [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
  int e_addr [8] = '{0, 0, 1, 2, 0, 0, 0, 0};
  int e_vld  [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
  int e_last [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int e_keep [8] = '{0, 0, 0, 255, 255, 15, 0, 0};
  int e_deq  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int e_busy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  int e_sel  [8] = '{0, 2, 2, 2, 2, 2, 2, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic int nwords(input int len);
    return (len + 7) / 8;
  endfunction

  function automatic int exp_keep(input int len, input int i);
    int nb;
    int rem;
    nb = nwords(len);
    if (i < nb - 1) return 255;
    rem = len - 8 * (nb - 1);
    return (1 << rem) - 1;
  endfunction

  task automatic update_head();
    if (q.size() != 0) begin
      fwd_token = 2'(q[0].tok);
      pkt_len   = LW'(q[0].len);
    end else begin
      fwd_token = 2'd0;
      pkt_len   = '0;
    end
  endtask

  task automatic push(input int tok, input int len);
    pkt_t p;
    p.tok = tok;
    p.len = len;
    q.push_back(p);
    update_head();
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", 64'(done), 64'd1);
  endtask

  // Packet buffer read port: one cycle latency.
  always @(posedge clk)
    if (rd_en && buf_sel != 2'd0) rd_data <= bufmem[int'(buf_sel) - 1][rd_addr];

  // Downstream ready generator.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        1:       begin axis.tready = pat[pat_i % 6]; pat_i++; end
        2:       axis.tready = ($urandom_range(0, 3) != 0);
        default: axis.tready = 1'b1;
      endcase
    end
  end

  // Scoreboard: read order, beat contents, stall stability, dequeue accounting.
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0; next_rd = 0; rd_issued = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld",  64'(axis.tvalid), 64'd1);
        check("stall_data", axis.tdata, prev_data);
        check("stall_keep", 64'(axis.tkeep), 64'(prev_keep));
        check("stall_last", 64'(axis.tlast), 64'(prev_last));
      end
      if (rd_en) begin
        if (q.size() == 0) check("rd_without_pkt", 64'd1, 64'd0);
        else begin
          check("rd_addr",  64'(rd_addr), 64'(next_rd));
          check("rd_sel",   64'(buf_sel), 64'(q[0].tok));
          check("rd_bound", 64'(int'(rd_addr) < nwords(q[0].len)), 64'd1);
        end
        next_rd++;
        rd_issued++;
      end
      if (busy && q.size() != 0) check("sel_hold", 64'(buf_sel), 64'(q[0].tok));
      if (axis.tvalid && axis.tready) begin
        if (q.size() == 0) check("beat_without_pkt", 64'd1, 64'd0);
        else begin
          check("beat_data", axis.tdata, bufmem[q[0].tok - 1][idx]);
          check("beat_keep", 64'(axis.tkeep), 64'(exp_keep(q[0].len, idx)));
          check("beat_last", 64'(axis.tlast), 64'(idx == nwords(q[0].len) - 1));
        end
        idx++;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_keep  = axis.tkeep;
      prev_last  = axis.tlast;
      if (fwd_deq) begin
        if (q.size() == 0) check("deq_without_pkt", 64'd1, 64'd0);
        else begin
          check("deq_beats", 64'(idx), 64'(nwords(q[0].len)));
          check("deq_reads", 64'(rd_issued), 64'(nwords(q[0].len)));
          q.pop_front();
          update_head();
        end
        idx = 0; next_rd = 0; rd_issued = 0;
        deq_cnt++;
      end
    end
  end

  initial begin
    int deq0;
    int gap;
    bit seen;
    rd_data = '0;
    fwd_token = 2'd0;
    pkt_len = '0;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 512; a++)
        bufmem[b][a] = {$urandom(), $urandom()};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_en",  64'(rd_en), 64'd0);
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_deq",    64'(fwd_deq), 64'd0);
    check("rst_sel",    64'(buf_sel), 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // token 2, 20 bytes: cycle-accurate timing table from T
    #2; push(2, 20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_rd_en_%0d", k),   64'(rd_en),        64'(e_rd[k]));
      check($sformatf("t1_rd_addr_%0d", k), 64'(rd_addr),      64'(e_addr[k]));
      check($sformatf("t1_tvalid_%0d", k),  64'(axis.tvalid),  64'(e_vld[k]));
      check($sformatf("t1_tlast_%0d", k),   64'(axis.tlast),   64'(e_last[k]));
      check($sformatf("t1_tkeep_%0d", k),   64'(axis.tkeep),   64'(e_keep[k]));
      check($sformatf("t1_deq_%0d", k),     64'(fwd_deq),      64'(e_deq[k]));
      check($sformatf("t1_busy_%0d", k),    64'(busy),         64'(e_busy[k]));
      check($sformatf("t1_sel_%0d", k),     64'(buf_sel),      64'(e_sel[k]));
    end

    // token 1, 16 bytes: exactly two full beats
    @(posedge clk); #2; push(1, 16);
    wait_idle(100);

    // 64 bytes under a stalling ready pattern
    tready_mode = 1;
    @(posedge clk); #2; push(2, 64);
    wait_idle(200);
    tready_mode = 0;

    // zero-length packet: straight to dequeue
    @(posedge clk); #2; push(3, 0);
    @(negedge clk);
    check("z_busy_T", 64'(busy), 64'd0);
    @(negedge clk);
    check("z_deq_T1",  64'(fwd_deq), 64'd1);
    check("z_busy_T1", 64'(busy), 64'd1);
    check("z_rd_T1",   64'(rd_en), 64'd0);
    check("z_vld_T1",  64'(axis.tvalid), 64'd0);
    @(negedge clk);
    check("z_deq_T2",  64'(fwd_deq), 64'd0);
    check("z_busy_T2", 64'(busy), 64'd0);

    // back-to-back tokens 1 then 3
    @(posedge clk); #2;
    deq0 = deq_cnt;
    push(1, 8);
    push(3, 8);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fwd_deq) begin seen = 1'b1; break; end
    end
    check("b2b_first_deq", 64'(seen), 64'd1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gap++;
      if (rd_en) break;
    end
    check("b2b_gap", 64'(gap), 64'd2);
    check("b2b_sel", 64'(buf_sel), 64'd3);
    wait_idle(100);
    check("b2b_deq_pulses", 64'(deq_cnt - deq0), 64'd2);

    // reset during beat 2 of 4, then the same token is re-read
    @(posedge clk); #2; push(2, 32);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (idx == 1) begin seen = 1'b1; break; end
    end
    check("rst_mid_reach", 64'(seen), 64'd1);
    deq0 = deq_cnt;
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    check("rstm_tvalid", 64'(axis.tvalid), 64'd0);
    check("rstm_rd_en",  64'(rd_en), 64'd0);
    check("rstm_busy",   64'(busy), 64'd0);
    check("rstm_sel",    64'(buf_sel), 64'd0);
    check("rstm_deq",    64'(fwd_deq), 64'd0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    check("rstm_no_deq", 64'(deq_cnt), 64'(deq0));
    wait_idle(100);
    check("rstm_one_deq", 64'(deq_cnt - deq0), 64'd1);

    // randomized traffic with random ready
    tready_mode = 2;
    @(posedge clk); #2;
    deq0 = deq_cnt;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) push($urandom_range(1, 3), $urandom_range(0, 4095));
      else                           push($urandom_range(1, 3), $urandom_range(0, 70));
    end
    wait_idle(40000);
    check("rand_deq_pulses", 64'(deq_cnt - deq0), 64'd40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
